// File: rtl/flit_inject_pkg.sv
// Shared flit format definitions for the injection port.
package flit_inject_pkg;

    localparam int unsigned FLIT_W    = 10;
    localparam int unsigned VALID_BIT = 9;
    localparam int unsigned DEST_MSB  = 8;
    localparam int unsigned DEST_LSB  = 6;
    localparam int unsigned DATA_MSB  = 5;
    localparam int unsigned DEST_W    = DEST_MSB - DEST_LSB + 1;
    localparam int unsigned DATA_W    = DATA_MSB + 1;

    localparam logic [DEST_W-1:0] EJECT_CODE0 = 3'b000;
    localparam logic [DEST_W-1:0] EJECT_CODE1 = 3'b001;

    typedef struct packed {
        logic              valid;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } flit_t;

    // Local-eject destinations must never be launched onto the network.
    function automatic logic is_eject(input logic [DEST_W-1:0] dest);
        return (dest == EJECT_CODE0) || (dest == EJECT_CODE1);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous FIFO with registered entry count; head is read from storage.
module flit_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               head_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == CW'(0));
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign head_c  = mem[rd_ptr];

    // Storage write; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/flit_inject.sv
// Core-to-network injection port: queues core flits and fills idle link slots.
module flit_inject
    import flit_inject_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLIT_W-1:0]          from_net,
    output logic [FLIT_W-1:0]          to_net,
    input  logic                       inj_valid,
    output logic                       inj_ready,
    input  logic [DEST_W-1:0]          inj_dest,
    input  logic [DATA_W-1:0]          inj_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       starve,
    output logic                       drop_err
);

    localparam int unsigned BW = $clog2(STARVE_LIM + 1);

    flit_t         head_c;
    flit_t         push_flit_c;
    logic          full_c;
    logic          empty_c;
    logic          link_busy_c;
    logic          accept_c;
    logic          illegal_c;
    logic          fifo_push_c;
    logic          pop_c;
    logic [BW-1:0] blocked;
    logic [BW-1:0] blocked_next_c;

    assign link_busy_c = from_net[VALID_BIT];
    assign inj_ready   = !full_c;
    assign accept_c    = inj_valid && inj_ready;
    assign illegal_c   = is_eject(inj_dest);
    assign fifo_push_c = accept_c && !illegal_c;
    assign pop_c       = !link_busy_c && !empty_c;
    assign push_flit_c = '{valid: 1'b1, dest: inj_dest, data: inj_data};

    flit_fifo #(
        .DEPTH (DEPTH),
        .W     (FLIT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push_c),
        .din     (push_flit_c),
        .pop     (pop_c),
        .head_c  (head_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .count   (occupancy)
    );

    // Blocked-cycle counter next value: saturating while the head waits.
    always_comb begin
        blocked_next_c = '0;
        if (!empty_c && link_busy_c) begin
            if (blocked == BW'(STARVE_LIM)) begin
                blocked_next_c = blocked;
            end else begin
                blocked_next_c = blocked + BW'(1);
            end
        end
    end

    // Link slot mux: through-traffic has priority, else launch the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_net <= '0;
        end else if (link_busy_c) begin
            to_net <= from_net;
        end else if (!empty_c) begin
            to_net <= head_c;
        end else begin
            to_net <= '0;
        end
    end

    // Starvation tracking and illegal-push reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            blocked  <= '0;
            starve   <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            blocked  <= blocked_next_c;
            starve   <= (blocked_next_c == BW'(STARVE_LIM));
            drop_err <= accept_c && illegal_c;
        end
    end

endmodule

// File: doc/flit_inject.md
FLIT_INJECT -- requirements
Module: flit_inject

Interface
REQ-001 Parameter DEPTH, 4: injection FIFO entries; power of two, minimum 2.
REQ-002 Parameter STARVE_LIM, 8: consecutive blocked cycles before starvation is flagged.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port from_net, input, 10: upstream link flit; [9] valid, [8:6] destination code, [5:0] payload.
REQ-006 Port to_net, output, 10: registered downstream link flit, same format, feeding the router input.
REQ-007 Port inj_valid, input, 1: core offers a flit.
REQ-008 Port inj_ready, output, 1: FIFO can accept a flit this cycle.
REQ-009 Port inj_dest, input, 3: destination code of the offered flit.
REQ-010 Port inj_data, input, 6: payload of the offered flit.
REQ-011 Port occupancy, output, clog2(DEPTH)+1: current FIFO entry count.
REQ-012 Port starve, output, 1: level; high while head-of-FIFO blocked for at least STARVE_LIM cycles.
REQ-013 Port drop_err, output, 1: one-cycle pulse on a discarded illegal push.

Function
REQ-014 inj_ready SHALL equal (occupancy < DEPTH), registered-state only; no combinational path from from_net.
REQ-015 Push occurs on an edge where inj_valid and inj_ready are both high.
REQ-016 A push with inj_dest 000 or 001 (local-eject codes) SHALL be consumed but not stored; drop_err SHALL be high in the next cycle.
REQ-017 Link slot rule, each edge: from_net[9]=1 -> to_net <= from_net (pass-through, priority over injection).
REQ-018 from_net[9]=0 and FIFO non-empty -> to_net <= {1'b1, head dest, head data}; pop head.
REQ-019 from_net[9]=0 and FIFO empty -> to_net <= 10'b0.
REQ-020 A flit pushed at edge N SHALL be eligible for pop at edge N+1 at the earliest; no same-edge bypass.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; data order strictly FIFO.
REQ-022 Full: inj_ready low; a pop at that edge reopens inj_ready in the following cycle.
REQ-023 Pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH or underflow.
REQ-024 Blocked counter: increments, saturating at STARVE_LIM, on each edge with FIFO non-empty and from_net[9]=1; clears on any pop or when FIFO empty.
REQ-025 starve SHALL be high when the blocked counter equals STARVE_LIM.
REQ-026 to_net[9] SHALL never be high with to_net[8:6] in {000,001} unless passed through from from_net.

Reset
REQ-027 On rst high at an edge: to_net=0, occupancy=0, pointers=0, blocked counter=0, starve=0, drop_err=0, inj_ready=1 the next cycle.
REQ-028 Reset mid-operation SHALL discard all queued flits; any push coincident with rst is ignored.
REQ-029 FIFO storage contents need not be reset.

Structure
REQ-030 Shared package holds flit field positions (VALID_BIT=9, DEST_MSB=8, DEST_LSB=6, DATA_MSB=5), a flit width constant of 10, and the local-eject codes 000/001.
REQ-031 One sub-module, flit_fifo (parameterised synchronous FIFO with count output), is instantiated; link slot mux, drop check and starvation counter live in flit_inject.

Verification
REQ-032 Idle link: push dest 010 data 0x15, from_net=0 -> to_net=10'b1_010_010101 two edges after push, occupancy back to 0.
REQ-033 Busy link: from_net=10'h3C5 for 10 cycles with 1 flit queued -> to_net mirrors from_net each edge, starve rises after 8th blocked edge, flit emitted on first idle slot, starve falls.
REQ-034 Fill: 5 back-to-back pushes, link busy -> 4 accepted, inj_ready low on 5th, occupancy=4; then link idle -> 4 flits out in push order.
REQ-035 Illegal: push dest 001 -> drop_err pulses one cycle, occupancy stays 0, to_net stays 0.
REQ-036 Reset mid-stream: 3 queued, assert rst one cycle -> occupancy=0, to_net=0, nothing emitted afterwards on idle link.
